// File: rtl/skeleton_capture_buffer.sv
// Captures skeleton waveform words after START up to the SMPL_END word, then serves them
// to the host bus one word per RD_REQ with a one-cycle registered read latency.
module skeleton_capture_buffer #(
  parameter int unsigned BITWIDTH_SYS = 16,
  parameter int unsigned DEPTH_LOG2   = 6
) (
  input  logic                    CLK_SYS,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic                    START,
  input  logic [BITWIDTH_SYS-1:0] SMPL_IN,
  input  logic                    SMPL_END,
  input  logic                    RD_REQ,
  output logic [BITWIDTH_SYS-1:0] DATA_OUT,
  output logic                    DATA_VALID,
  output logic [DEPTH_LOG2:0]     CNT_STORED,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVF
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CntOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCapture, StReadout} state_e;

  state_e state_q, state_d;

  logic [BITWIDTH_SYS-1:0] mem [Depth];

  // cnt_q doubles as the write pointer since writes never wrap within a capture.
  logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
  logic [DEPTH_LOG2:0]     rd_ptr_q, rd_ptr_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic                    rd_pend_q;
  logic                    rd_last_q;
  logic [DEPTH_LOG2-1:0]   rd_addr_q;
  logic [BITWIDTH_SYS-1:0] data_out_q;
  logic                    data_valid_q;

  logic full;
  logic wr_en;
  logic rd_issue;
  logic rd_last_issue;
  logic arm;

  assign full = cnt_q[DEPTH_LOG2];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_ptr_d      = rd_ptr_q;
    ovf_d         = ovf_q;
    done_d        = done_q;
    wr_en         = 1'b0;
    rd_issue      = 1'b0;
    rd_last_issue = 1'b0;
    arm           = 1'b0;

    // DONE falls on the same edge that presents the final word.
    if (rd_pend_q && rd_last_q) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (START) begin
          arm = 1'b1;
        end
      end
      StCapture: begin
        if (EN) begin
          if (!full) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CntOne;
          end else begin
            ovf_d = 1'b1;
          end
          if (SMPL_END) begin
            state_d = StReadout;
            done_d  = 1'b1;
          end
        end
      end
      StReadout: begin
        if (START) begin
          arm = 1'b1;
        end else if (RD_REQ && (rd_ptr_q < cnt_q)) begin
          rd_issue = 1'b1;
          rd_ptr_d = rd_ptr_q + CntOne;
          if (rd_ptr_q == cnt_q - CntOne) begin
            rd_last_issue = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (arm) begin
      state_d  = StCapture;
      cnt_d    = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_addr_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      rd_pend_q    <= rd_issue;
      rd_last_q    <= rd_last_issue;
      data_valid_q <= rd_pend_q;
      if (rd_issue) begin
        rd_addr_q <= rd_ptr_q[DEPTH_LOG2-1:0];
      end
      if (rd_pend_q) begin
        data_out_q <= mem[rd_addr_q];
      end
    end
  end

  // Storage is deliberately left out of reset; only pointers and flags are cleared.
  always_ff @(posedge CLK_SYS) begin
    if (wr_en) begin
      mem[cnt_q[DEPTH_LOG2-1:0]] <= SMPL_IN;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign CNT_STORED = cnt_q;
  assign BUSY       = (state_q == StCapture);
  assign DONE       = done_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_skeleton_capture_buffer.sv
// Bench for skeleton_capture_buffer: vector table for capture phases, scoreboard queue for reads.
module tb_skeleton_capture_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        send = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        dv;
  logic [6:0]  cnt;
  logic        busy;
  logic        done;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid = 0;

  typedef struct {
    logic        start;
    logic        en;
    logic        send;
    logic [15:0] din;
    logic [6:0]  cnt;
    logic        busy;
    logic        done;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  vec_t        vecs [14];
  exp_t        sbq [$];
  exp_t        e;
  logic [15:0] cap [$];
  int          rd_idx = 0;
  bit          m_cap = 1'b0;
  bit          m_rdout = 1'b0;

  skeleton_capture_buffer #(
    .BITWIDTH_SYS(16),
    .DEPTH_LOG2  (6)
  ) dut (
    .CLK_SYS   (clk),
    .RSTN      (rstn),
    .EN        (en),
    .START     (start),
    .SMPL_IN   (din),
    .SMPL_END  (send),
    .RD_REQ    (rd),
    .DATA_OUT  (dout),
    .DATA_VALID(dv),
    .CNT_STORED(cnt),
    .BUSY      (busy),
    .DONE      (done),
    .OVF       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read monitor: every DATA_VALID must match the oldest expected word at its due cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_valid: got no DATA_VALID, required %h at cycle %0d",
               sbq[0].data, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (dv === 1'b1) begin
      nvalid++;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got DATA_VALID with %h, required none", dout);
      end else begin
        e = sbq.pop_front();
        check("read_data", 32'(dout), 32'(e.data));
        check("read_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_start();
    cap.delete();
    rd_idx  = 0;
    m_cap   = 1'b1;
    m_rdout = 1'b0;
  endtask

  task automatic model_word(input logic [15:0] d, input logic last);
    if (m_cap) begin
      if (cap.size() < 64) cap.push_back(d);
      if (last) begin
        m_cap   = 1'b0;
        m_rdout = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    cap.delete();
    sbq.delete();
    rd_idx  = 0;
    m_cap   = 1'b0;
    m_rdout = 1'b0;
  endtask

  task automatic drive_rd();
    rd = 1'b1;
    if (m_rdout && rd_idx < cap.size()) begin
      sbq.push_back('{cap[rd_idx], cyc + 2});
      rd_idx++;
      if (rd_idx == cap.size()) m_rdout = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    model_start();
    tick();
    start = 1'b0;
  endtask

  task automatic capture_word(input logic [15:0] d, input logic last);
    en   = 1'b1;
    din  = d;
    send = last;
    model_word(d, last);
    tick();
    en   = 1'b0;
    send = 1'b0;
  endtask

  task automatic read_pulse();
    drive_rd();
    tick();
    rd = 1'b0;
  endtask

  task automatic read_hold(input int n);
    for (int i = 0; i < n; i++) begin
      drive_rd();
      tick();
    end
    rd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) tick();
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start = vecs[i].start;
      en    = vecs[i].en;
      send  = vecs[i].send;
      din   = vecs[i].din;
      if (vecs[i].start) model_start();
      else if (vecs[i].en) model_word(vecs[i].din, vecs[i].send);
      tick();
      start = 1'b0;
      en    = 1'b0;
      send  = 1'b0;
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_valid"}, 32'(dv), 32'd0);
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    // start en send din cnt busy done ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 7'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 7'd1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0200, 7'd2, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0300, 7'd3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 7'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h1111, 7'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'hdead, 7'd1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h2222, 7'd2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'hbeef, 7'd2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h3333, 7'd3, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'hdead, 7'd3, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h4444, 7'd4, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'hbeef, 7'd4, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h5555, 7'd5, 1'b0, 1'b1, 1'b0};

    #1 rstn = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Basic capture and single-pulse readout
    apply(0, 3);
    read_pulse();
    tick();
    read_pulse();
    tick();
    drive_rd();
    tick();
    rd = 1'b0;
    check("done_before_last", 32'(done), 32'd1);
    check("busy_readout", 32'(busy), 32'd0);
    tick();
    check("last_valid", 32'(dv), 32'd1);
    check("done_with_last", 32'(done), 32'd0);
    tick();
    check("valid_after_last", 32'(dv), 32'd0);
    read_hold(2);
    check("cnt_kept_idle", 32'(cnt), 32'd3);
    drain();

    // EN gating, with SMPL_END while EN=0 ignored
    apply(4, 13);
    read_hold(5);
    drain();

    // Overflow: 70 words into 64 slots
    do_start();
    for (int i = 1; i <= 70; i++) capture_word(16'(i), (i == 70) ? 1'b1 : 1'b0);
    check("ovf_cnt", 32'(cnt), 32'd64);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    read_hold(64);
    drain();
    check("ovf_done_after", 32'(done), 32'd0);
    check("ovf_kept_idle", 32'(ovf), 32'd1);
    check("ovf_cnt_idle", 32'(cnt), 32'd64);

    // Back-to-back streaming with extra requests past the end
    do_start();
    for (int i = 1; i <= 10; i++) capture_word(16'hA000 + 16'(i), (i == 10) ? 1'b1 : 1'b0);
    begin
      int n0;
      n0 = nvalid;
      read_hold(12);
      drain();
      check("stream_count", 32'(nvalid - n0), 32'd10);
    end

    // Abort during readout with a simultaneous RD_REQ
    do_start();
    for (int i = 1; i <= 5; i++) capture_word(16'hB000 + 16'(i), (i == 5) ? 1'b1 : 1'b0);
    read_pulse();
    tick();
    read_pulse();
    tick();
    start = 1'b1;
    rd    = 1'b1;
    model_start();
    tick();
    start = 1'b0;
    rd    = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_cnt", 32'(cnt), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_no_valid", 32'(dv), 32'd0);
    capture_word(16'hC001, 1'b0);
    capture_word(16'hC002, 1'b1);
    check("abort_new_cnt", 32'(cnt), 32'd2);
    read_hold(2);
    drain();

    // Async reset mid-capture
    do_start();
    capture_word(16'hD001, 1'b0);
    capture_word(16'hD002, 1'b0);
    #3 rstn = 1'b0;
    model_reset();
    #1 check_all_zero("rst_capture");
    tick();
    rstn = 1'b1;
    tick();

    // Async reset mid-readout with a read in flight
    do_start();
    for (int i = 1; i <= 3; i++) capture_word(16'hE000 + 16'(i), (i == 3) ? 1'b1 : 1'b0);
    read_pulse();
    tick();
    drive_rd();
    @(posedge clk);
    #2 rstn = 1'b0;
    rd = 1'b0;
    model_reset();
    #1 check_all_zero("rst_readout");
    tick();
    check("rst_no_valid", 32'(dv), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("rst_quiet_valid", 32'(dv), 32'd0);

    do_start();
    check("post_rst_busy", 32'(busy), 32'd1);
    capture_word(16'hF001, 1'b0);
    capture_word(16'hF002, 1'b1);
    check("post_rst_cnt", 32'(cnt), 32'd2);
    read_hold(2);
    drain();
    check("post_rst_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/skeleton_capture_buffer.md
# skeleton_capture_buffer

Capture stage placed directly downstream of the ROM test skeleton on the FPGA test design. It records the waveform words the skeleton emits after a calculation trigger, up to and including the word flagged by the skeleton's ready/end strobe. It holds them in an on-chip buffer and then serves them word-by-word to the host-side data bus on read strobes. Overflow and progress flags let the host tell a complete capture from a truncated one.

## Interface
Parameters:
- BITWIDTH_SYS, 16: width of the data bus and of each stored word.
- DEPTH_LOG2, 6: buffer depth is 2^DEPTH_LOG2 words (64 by default).

Ports:
- CLK_SYS  in  1  system clock; all state updates on the rising edge.
- RSTN  in  1  reset; asynchronous, active-low.
- EN  in  1  sample-qualify; a skeleton word is taken only on cycles with EN=1.
- START  in  1  one-cycle pulse; arms a new capture. It is the same strobe that triggers the skeleton.
- SMPL_IN  in  BITWIDTH_SYS  word from the skeleton data output.
- SMPL_END  in  1  skeleton ready/end flag; marks SMPL_IN as the last word.
- RD_REQ  in  1  host read strobe; one word per asserted cycle.
- DATA_OUT  out  BITWIDTH_SYS  read data, registered.
- DATA_VALID  out  1  DATA_OUT holds a valid word this cycle.
- CNT_STORED  out  DEPTH_LOG2+1  number of words stored in the current or last capture.
- BUSY  out  1  capture in progress.
- DONE  out  1  capture finished and readout pending.
- OVF  out  1  at least one word was dropped because the buffer was full.

## Operation
- FSM states: IDLE, CAPTURE, READOUT. Reset state is IDLE.
- IDLE:
  - START=1 -> CAPTURE.
  - On that transition: write pointer, read pointer and CNT_STORED clear to 0; OVF and DONE clear to 0.
  - RD_REQ is ignored.
- CAPTURE:
  - On each cycle with EN=1 and CNT_STORED < 2^DEPTH_LOG2: mem[wr_ptr] <= SMPL_IN, and wr_ptr and CNT_STORED each increment by 1.
  - EN=1 with the buffer full: the word is dropped and OVF <= 1 (sticky until the next START or reset).
  - EN=0: no write. SMPL_END is ignored.
  - EN=1 and SMPL_END=1: the word is stored, or dropped with OVF if full, then -> READOUT.
  - START and RD_REQ are ignored.
- READOUT:
  - DONE=1.
  - RD_REQ=1 with rd_ptr < CNT_STORED: a read of mem[rd_ptr] is issued and rd_ptr increments.
  - When the read of index CNT_STORED-1 is issued: -> IDLE, and DONE drops together with that word's DATA_VALID.
  - START=1 aborts the readout and re-arms: identical to the IDLE->CAPTURE transition. START takes priority over a simultaneous RD_REQ.
- Buffer contents are not cleared on reset or START. Only pointers, counters and flags are cleared.
- CNT_STORED saturates at 2^DEPTH_LOG2 and never wraps. The pointers never wrap within a capture.
- Outputs by state:
  - BUSY = (state==CAPTURE).
  - DATA_OUT keeps its last value when DATA_VALID=0.
  - CNT_STORED and OVF remain readable in IDLE after readout until the next START.
- Reset mid-operation (any state): all outputs go to their reset values immediately, the FSM returns to IDLE, and any in-flight read is discarded.

## Timing
- Reset values: DATA_OUT=0, DATA_VALID=0, CNT_STORED=0, BUSY=0, DONE=0, OVF=0.
- START sampled at edge k: BUSY=1 after edge k. The first word can be written at edge k+1 if EN=1.
- A word sampled at edge n is counted in CNT_STORED after edge n.
- SMPL_END sampled at edge n: BUSY=0 and DONE=1 after edge n.
- RD_REQ sampled at edge n: DATA_OUT/DATA_VALID valid after edge n+1, for one cycle. Read latency is 1 cycle.
- RD_REQ held high streams one word per cycle with no bubbles.
- RD_REQ with no unread words, or outside READOUT: no DATA_VALID.

## Test plan
- Basic capture/readout:
  - Stimulus: START; EN=1; SMPL_IN = 0x0100,0x0200,0x0300; SMPL_END on the third word.
  - Required: CNT_STORED=3, DONE=1, OVF=0.
  - Then three RD_REQ pulses give DATA_OUT 0x0100,0x0200,0x0300, each one cycle after its request. DONE clears with the last word; state returns to IDLE.
- EN gating:
  - Stimulus: 5-word capture with EN low every other cycle, and SMPL_END asserted while EN=0 on one cycle.
  - Required: only EN=1 words are stored. The EN=0 SMPL_END is ignored; the capture ends only on an EN=1 SMPL_END.
- Overflow:
  - Stimulus: 70 words with EN=1, SMPL_END on the 70th.
  - Required: CNT_STORED=64, OVF=1. Readout returns words 1..64 in order.
- Back-to-back streaming:
  - Stimulus: RD_REQ held high for 10 cycles after a 10-word capture.
  - Required: DATA_VALID high for 10 consecutive cycles with the correct sequence. No extra DATA_VALID after that.
- Abort and restart:
  - Stimulus: START during READOUT after 2 of 5 words have been read, followed by a simultaneous RD_REQ.
  - Required: no DATA_VALID for the RD_REQ. BUSY=1, CNT_STORED=0 and OVF=0 after the edge. The new capture proceeds normally.
- Async reset:
  - Stimulus: RSTN low mid-CAPTURE (not aligned to a clock edge), then mid-READOUT.
  - Required: all outputs go to 0 immediately, with no DATA_VALID pulse afterwards. The next START works normally.
